// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: runs the req/ack data-memory handshake for loads and stores and drives the
// register-file write port. Define MEM_TIMEOUT_EN to add the BUSY-state ack timeout and memError pulse.
module mem_writeback_stage #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TIMEOUT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  inWrtIndex,
   input  logic        inRegWrEn,
   input  logic [1:0]  inMulSel,
   input  logic [31:0] inAluOut,
   input  logic [31:0] inData2Out,
   input  logic [31:0] inPC,
   input  logic        inIsLoad,
   input  logic        inIsStore,
   output logic        dmemReq,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWrData,
   output logic        dmemWrEn,
   input  logic        dmemAck,
   input  logic [31:0] dmemRdData,
   output logic        rfWrEn,
   output logic [3:0]  rfWrtIndex,
   output logic [31:0] rfWrtData,
   output logic        memStall,
   output logic        memError
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        w_mem_op;
   logic        w_timeout;

   // Instruction fields held across the memory access; the ALU result lives in r_dmem_addr.
   logic [3:0]  r_hold_index;
   logic        r_hold_wren;
   logic [1:0]  r_hold_sel;
   logic [31:0] r_hold_pc;

   logic        r_dmem_req;
   logic [31:0] r_dmem_addr;
   logic [31:0] r_dmem_wr_data;
   logic        r_dmem_wr_en;
   logic        r_rf_wr_en;
   logic [3:0]  r_rf_wrt_index;
   logic [31:0] r_rf_wrt_data;

   // Writeback mux; 00 and 11 both select the ALU result, PC+4 wraps modulo 2^32.
   function automatic logic [31:0] wb_select(
      input logic [1:0]  sel,
      input logic [31:0] alu,
      input logic [31:0] rd_data,
      input logic [31:0] pc
   );
      logic [31:0] result;
      result = alu;
      if (sel == SEL_LOAD) begin
         result = rd_data;
      end else if (sel == SEL_LINK) begin
         result = pc + 32'd4;
      end
      return result;
   endfunction

   if (MEM_TIMEOUT == 0 || 64'(MEM_TIMEOUT) >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
      $error("MEM_TIMEOUT must be nonzero and fit in TIMEOUT_W bits");
   end

   assign w_mem_op = inIsLoad || inIsStore;

`ifdef MEM_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_cnt;
   logic                 r_mem_error;

   // The limit is hit in the cycle whose missing ack would take the count to MEM_TIMEOUT.
   assign w_timeout = (r_state == ST_BUSY) && !dmemAck &&
                      (r_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_mem_error <= w_timeout;
         if (r_state == ST_IDLE) begin
            r_cnt <= '0;
         end else if (!dmemAck) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
         end
      end
   end

   assign memError = r_mem_error;
`else
   assign w_timeout = 1'b0;
   assign memError  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path through this block can infer a latch.
      w_state_nxt = r_state;
      if (r_state == ST_IDLE) begin
         if (w_mem_op) begin
            w_state_nxt = ST_BUSY;
         end
      end else begin
         if (dmemAck || w_timeout) begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold_index   <= '0;
         r_hold_wren    <= 1'b0;
         r_hold_sel     <= '0;
         r_hold_pc      <= '0;
         r_dmem_req     <= 1'b0;
         r_dmem_addr    <= '0;
         r_dmem_wr_data <= '0;
         r_dmem_wr_en   <= 1'b0;
         r_rf_wr_en     <= 1'b0;
         r_rf_wrt_index <= '0;
         r_rf_wrt_data  <= '0;
      end else if (r_state == ST_IDLE) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_mem_op) begin
            r_hold_index   <= inWrtIndex;
            r_hold_wren    <= inRegWrEn;
            r_hold_sel     <= inMulSel;
            r_hold_pc      <= inPC;
            r_dmem_addr    <= inAluOut;
            r_dmem_wr_data <= inData2Out;
            r_dmem_wr_en   <= inIsStore;
            r_dmem_req     <= 1'b1;
            r_rf_wr_en     <= 1'b0;
         end else begin
            r_rf_wr_en     <= inRegWrEn;
            r_rf_wrt_index <= inWrtIndex;
            r_rf_wrt_data  <= wb_select(inMulSel, inAluOut, dmemRdData, inPC);
         end
      end else begin
         r_rf_wr_en <= 1'b0;
         if (dmemAck) begin
            r_dmem_req <= 1'b0;
            if (!r_dmem_wr_en) begin
               r_rf_wr_en     <= r_hold_wren;
               r_rf_wrt_index <= r_hold_index;
               r_rf_wrt_data  <= wb_select(r_hold_sel, r_dmem_addr, dmemRdData, r_hold_pc);
            end
         end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
         end
      end
   end

   assign memStall = ((r_state == ST_IDLE) && w_mem_op) ||
                     ((r_state == ST_BUSY) && !dmemAck && !w_timeout);

   assign dmemReq    = r_dmem_req;
   assign dmemAddr   = r_dmem_addr;
   assign dmemWrData = r_dmem_wr_data;
   assign dmemWrEn   = r_dmem_wr_en;
   assign rfWrEn     = r_rf_wr_en;
   assign rfWrtIndex = r_rf_wrt_index;
   assign rfWrtData  = r_rf_wrt_data;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage; define MEM_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_writeback_stage;

   logic        clk;
   logic        reset;
   logic [3:0]  inWrtIndex;
   logic        inRegWrEn;
   logic [1:0]  inMulSel;
   logic [31:0] inAluOut;
   logic [31:0] inData2Out;
   logic [31:0] inPC;
   logic        inIsLoad;
   logic        inIsStore;
   logic        dmemReq;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWrData;
   logic        dmemWrEn;
   logic        dmemAck;
   logic [31:0] dmemRdData;
   logic        rfWrEn;
   logic [3:0]  rfWrtIndex;
   logic [31:0] rfWrtData;
   logic        memStall;
   logic        memError;

   int n_errors = 0;
   int n_checks = 0;

   mem_writeback_stage #(
      .MEM_TIMEOUT(4),
      .TIMEOUT_W  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .inWrtIndex (inWrtIndex),
      .inRegWrEn  (inRegWrEn),
      .inMulSel   (inMulSel),
      .inAluOut   (inAluOut),
      .inData2Out (inData2Out),
      .inPC       (inPC),
      .inIsLoad   (inIsLoad),
      .inIsStore  (inIsStore),
      .dmemReq    (dmemReq),
      .dmemAddr   (dmemAddr),
      .dmemWrData (dmemWrData),
      .dmemWrEn   (dmemWrEn),
      .dmemAck    (dmemAck),
      .dmemRdData (dmemRdData),
      .rfWrEn     (rfWrEn),
      .rfWrtIndex (rfWrtIndex),
      .rfWrtData  (rfWrtData),
      .memStall   (memStall),
      .memError   (memError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      inWrtIndex = 4'd0;
      inRegWrEn  = 1'b0;
      inMulSel   = 2'b00;
      inAluOut   = 32'h0;
      inData2Out = 32'h0;
      inPC       = 32'h0;
      inIsLoad   = 1'b0;
      inIsStore  = 1'b0;
   endtask

   task automatic present(input logic [3:0] idx, input logic wren, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
                          input logic ld, input logic st);
      inWrtIndex = idx;
      inRegWrEn  = wren;
      inMulSel   = sel;
      inAluOut   = alu;
      inData2Out = d2;
      inPC       = pc;
      inIsLoad   = ld;
      inIsStore  = st;
   endtask

   initial begin
      bubble();
      dmemAck    = 1'b0;
      dmemRdData = 32'h0;
      reset      = 1'b0;
      #23;
      check("rst_dmemReq",   32'(dmemReq),   32'h0);
      check("rst_rfWrEn",    32'(rfWrEn),    32'h0);
      check("rst_rfWrtData", rfWrtData,      32'h0);
      check("rst_dmemAddr",  dmemAddr,       32'h0);
      check("rst_memStall",  32'(memStall),  32'h0);
      check("rst_memError",  32'(memError),  32'h0);
      reset = 1'b1;
      tick();

      // ALU writeback, one-cycle latency
      present(4'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h100, 1'b0, 1'b0);
      #1 check("alu_stall", 32'(memStall), 32'h0);
      tick();
      check("alu_wren",  32'(rfWrEn),     32'h1);
      check("alu_index", 32'(rfWrtIndex), 32'h5);
      check("alu_data",  rfWrtData,       32'h1234);

      // PC+4 wraps to zero
      present(4'd1, 1'b1, 2'b10, 32'h55, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
      tick();
      check("link_wrap_data", rfWrtData, 32'h0);
      check("link_wrap_idx",  32'(rfWrtIndex), 32'h1);

      // Select 11 is the ALU result
      present(4'd2, 1'b1, 2'b11, 32'hA5A5_0001, 32'h0, 32'h200, 1'b0, 1'b0);
      tick();
      check("sel11_data", rfWrtData, 32'hA5A5_0001);

      // Bubble with a stray ack: no write, no request
      bubble();
      dmemAck = 1'b1;
      #1 check("stray_ack_stall", 32'(memStall), 32'h0);
      tick();
      dmemAck = 1'b0;
      check("bubble_wren",   32'(rfWrEn),  32'h0);
      check("stray_ack_req", 32'(dmemReq), 32'h0);

      // Load, ack in the third request cycle
      present(4'd7, 1'b1, 2'b01, 32'h40, 32'h1111, 32'h300, 1'b1, 1'b0);
      #1;
      check("ld_c0_stall", 32'(memStall), 32'h1);
      check("ld_c0_req",   32'(dmemReq),  32'h0);
      tick();
      present(4'd9, 1'b1, 2'b00, 32'h999, 32'h2222, 32'h400, 1'b0, 1'b0);
      #1;
      check("ld_c1_req",   32'(dmemReq),  32'h1);
      check("ld_c1_addr",  dmemAddr,      32'h40);
      check("ld_c1_wren",  32'(dmemWrEn), 32'h0);
      check("ld_c1_stall", 32'(memStall), 32'h1);
      check("ld_c1_rf",    32'(rfWrEn),   32'h0);
      tick();
      check("ld_c2_req",   32'(dmemReq),  32'h1);
      check("ld_c2_addr",  dmemAddr,      32'h40);
      check("ld_c2_stall", 32'(memStall), 32'h1);
      tick();
      dmemAck    = 1'b1;
      dmemRdData = 32'hCAFE_F00D;
      #1;
      check("ld_c3_req",   32'(dmemReq),  32'h1);
      check("ld_c3_stall", 32'(memStall), 32'h0);
      check("ld_c3_rf",    32'(rfWrEn),   32'h0);
      tick();
      dmemAck    = 1'b0;
      dmemRdData = 32'h0;
      bubble();
      check("ld_wb_wren",  32'(rfWrEn),     32'h1);
      check("ld_wb_index", 32'(rfWrtIndex), 32'h7);
      check("ld_wb_data",  rfWrtData,       32'hCAFE_F00D);
      check("ld_wb_req",   32'(dmemReq),    32'h0);
      tick();
      check("ld_pulse_end", 32'(rfWrEn), 32'h0);

      // Store with inRegWrEn=1 and immediate ack: never writes back
      present(4'd9, 1'b1, 2'b00, 32'h80, 32'hDEAD_BEEF, 32'h500, 1'b0, 1'b1);
      #1 check("st_c0_stall", 32'(memStall), 32'h1);
      tick();
      bubble();
      check("st_req",   32'(dmemReq),  32'h1);
      check("st_wren",  32'(dmemWrEn), 32'h1);
      check("st_wdata", dmemWrData,    32'hDEAD_BEEF);
      check("st_addr",  dmemAddr,      32'h80);
      dmemAck = 1'b1;
      #1 check("st_c1_stall", 32'(memStall), 32'h0);
      tick();
      dmemAck = 1'b0;
      check("st_c2_rf",  32'(rfWrEn),  32'h0);
      check("st_c2_req", 32'(dmemReq), 32'h0);
      tick();
      check("st_c3_rf", 32'(rfWrEn), 32'h0);

      // Load with select 00 writes the captured ALU result
      present(4'd3, 1'b1, 2'b00, 32'h55, 32'h0, 32'h600, 1'b1, 1'b0);
      tick();
      present(4'd4, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0);
      dmemAck    = 1'b1;
      dmemRdData = 32'h1357_9BDF;
      tick();
      dmemAck    = 1'b0;
      bubble();
      check("ld_alu_wren",  32'(rfWrEn),     32'h1);
      check("ld_alu_index", 32'(rfWrtIndex), 32'h3);
      check("ld_alu_data",  rfWrtData,       32'h55);

      // Reset mid-access: request drops asynchronously, no writeback
      present(4'd6, 1'b1, 2'b01, 32'h90, 32'h0, 32'h700, 1'b1, 1'b0);
      tick();
      bubble();
      check("rb_req_before", 32'(dmemReq), 32'h1);
      #2 reset = 1'b0;
      #1 check("rb_req_async", 32'(dmemReq), 32'h0);
      dmemAck = 1'b1;
      tick();
      dmemAck = 1'b0;
      check("rb_rf_in_reset", 32'(rfWrEn), 32'h0);
      #2 reset = 1'b1;
      tick();
      check("rb_rf_after", 32'(rfWrEn),  32'h0);
      check("rb_req_after", 32'(dmemReq), 32'h0);
      present(4'd4, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      bubble();
      check("rb_alu_wren", 32'(rfWrEn),     32'h1);
      check("rb_alu_idx",  32'(rfWrtIndex), 32'h4);
      check("rb_alu_data", rfWrtData,       32'h77);
      tick();

`ifdef MEM_TIMEOUT_EN
      // Timeout after four unacknowledged request cycles
      present(4'd8, 1'b1, 2'b01, 32'hC0, 32'h0, 32'h800, 1'b1, 1'b0);
      tick();
      bubble();
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("to_c%0d_req", c), 32'(dmemReq),  32'h1);
         check($sformatf("to_c%0d_err", c), 32'(memError), 32'h0);
         check($sformatf("to_c%0d_stall", c), 32'(memStall), (c == 4) ? 32'h0 : 32'h1);
         tick();
      end
      check("to_err_pulse", 32'(memError), 32'h1);
      check("to_req_drop",  32'(dmemReq),  32'h0);
      check("to_no_wb",     32'(rfWrEn),   32'h0);
      tick();
      check("to_err_end",   32'(memError), 32'h0);
      check("to_idle_req",  32'(dmemReq),  32'h0);
`else
      check("no_to_memError", 32'(memError), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
